// File: rtl/seq_bbccc_gen_pkg.sv
// Shared definitions for the BBCCC serial pattern generator.
//   state_t        : one-hot state encoding of the frame sequencer
//   DEF_*_SYM      : default symbol values for B, C and idle line level
//   FRAME_LEN      : number of symbols in one B,B,C,C,C frame
package seq_pkg;

  typedef enum logic [6:0] {
    S_IDLE = 7'b000_0001,
    S_B1   = 7'b000_0010,
    S_B2   = 7'b000_0100,
    S_C1   = 7'b000_1000,
    S_C2   = 7'b001_0000,
    S_C3   = 7'b010_0000,
    S_GAP  = 7'b100_0000
  } state_t;

  localparam logic DEF_B_SYM    = 1'b0;
  localparam logic DEF_C_SYM    = 1'b1;
  localparam logic DEF_IDLE_SYM = 1'b1;

  localparam int unsigned FRAME_LEN = 5;

  // True for the five states that put a frame symbol on the line.
  function automatic logic is_frame_state(input state_t s);
    return (s inside {S_B1, S_B2, S_C1, S_C2, S_C3});
  endfunction

endpackage

// File: rtl/seq_bbccc_gen_gap_cnt.sv
// Inter-frame gap timer for seq_bbccc_gen.
//   clk     : rising-edge clock
//   rst     : synchronous active-high reset
//   load    : asserted on the edge that enters the gap state
//   expired : high during the last gap cycle (count has reached zero)
// Loaded with GAP_LEN-1 so that the sequencer spends exactly GAP_LEN cycles
// in the gap state. Never loaded when GAP_LEN=0 (the gap state is skipped).
module seq_gap_cnt #(
  parameter int unsigned GAP_LEN = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic expired
);

  localparam int unsigned GW = (GAP_LEN > 2) ? $clog2(GAP_LEN) : 1;
  localparam logic [GW-1:0] LOAD_VAL = (GAP_LEN > 0) ? GW'(GAP_LEN - 1) : '0;

  logic [GW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= LOAD_VAL;
    end else if (cnt != '0) begin
      cnt <= cnt - GW'(1);
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/seq_bbccc_gen.sv
// BBCCC serial pattern generator (transmit end of the BBCCC detector link).
//   clk       : rising-edge clock
//   rst       : synchronous active-high reset, overrides all inputs
//   start     : request, sampled only while idle
//   reps      : frames to send, latched on accepted start (0 sends one frame)
//   stop      : abort, returns to idle at the next edge without a done pulse
//   dout      : serial symbol (IDLE_SYM when no symbol is valid)
//   dout_vld  : dout carries a frame symbol
//   busy      : high from accepted start until return to idle
//   done      : one-cycle pulse after the last symbol of the last frame
//   frame_cnt : frames fully sent in the current request (saturating)
// All outputs are registered; they are decoded from the next state so the
// first symbol appears the cycle after start is sampled.
module seq_bbccc_gen
  import seq_pkg::*;
#(
  parameter logic        B_SYM    = DEF_B_SYM,
  parameter logic        C_SYM    = DEF_C_SYM,
  parameter logic        IDLE_SYM = DEF_IDLE_SYM,
  parameter int unsigned CNT_W    = 4,
  parameter int unsigned GAP_LEN  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] reps,
  input  logic             stop,
  output logic             dout,
  output logic             dout_vld,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] frame_cnt
);

  state_t           state_q, state_nxt;
  logic [CNT_W-1:0] reps_q, reps_nxt;
  logic [CNT_W-1:0] cnt_nxt, cnt_inc;
  logic             done_nxt;
  logic             load_gap;
  logic             gap_done;
  logic             dout_nxt;

  seq_gap_cnt #(
    .GAP_LEN (GAP_LEN)
  ) u_gap (
    .clk     (clk),
    .rst     (rst),
    .load    (load_gap),
    .expired (gap_done)
  );

  always_comb begin
    state_nxt = state_q;
    reps_nxt  = reps_q;
    cnt_nxt   = frame_cnt;
    done_nxt  = 1'b0;
    load_gap  = 1'b0;
    cnt_inc   = (frame_cnt == '1) ? frame_cnt : frame_cnt + CNT_W'(1);

    unique case (state_q)
      S_IDLE: begin
        if (start && !stop) begin
          state_nxt = S_B1;
          reps_nxt  = (reps == '0) ? CNT_W'(1) : reps;
          cnt_nxt   = '0;
        end
      end
      S_B1: state_nxt = S_B2;
      S_B2: state_nxt = S_C1;
      S_C1: state_nxt = S_C2;
      S_C2: state_nxt = S_C3;
      S_C3: begin
        cnt_nxt = cnt_inc;
        if (cnt_inc == reps_q) begin
          state_nxt = S_IDLE;
          done_nxt  = 1'b1;
        end else if (GAP_LEN > 0) begin
          state_nxt = S_GAP;
          load_gap  = 1'b1;
        end else begin
          state_nxt = S_B1;
        end
      end
      S_GAP: begin
        if (gap_done) begin
          state_nxt = S_B1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    // Abort takes priority over every transition decided above, including
    // the frame count update and done pulse when leaving S_C3.
    if (stop && (state_q != S_IDLE)) begin
      state_nxt = S_IDLE;
      cnt_nxt   = frame_cnt;
      done_nxt  = 1'b0;
      load_gap  = 1'b0;
    end

    if (state_nxt inside {S_B1, S_B2}) begin
      dout_nxt = B_SYM;
    end else if (state_nxt inside {S_C1, S_C2, S_C3}) begin
      dout_nxt = C_SYM;
    end else begin
      dout_nxt = IDLE_SYM;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      reps_q    <= '0;
      frame_cnt <= '0;
      dout      <= IDLE_SYM;
      dout_vld  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      reps_q    <= reps_nxt;
      frame_cnt <= cnt_nxt;
      dout      <= dout_nxt;
      dout_vld  <= is_frame_state(state_nxt);
      busy      <= (state_nxt != S_IDLE);
      done      <= done_nxt;
    end
  end

endmodule

// File: tb/tb_seq_bbccc_gen.sv
// Self-checking bench for seq_bbccc_gen: a request model predicts every
// symbol (with the cycle it must appear on) and every done pulse; a monitor
// pops and compares whenever the DUT presents a symbol or a done pulse.
module tb_seq_bbccc_gen;

  localparam int unsigned CNT_W = 4;
  localparam int unsigned G     = 2;
  localparam int unsigned FL    = 5;
  localparam int unsigned P     = FL + G;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic [CNT_W-1:0] reps = '0;
  logic             dout, dout_vld, busy, done;
  logic [CNT_W-1:0] frame_cnt;

  int unsigned checks = 0;
  int unsigned failures = 0;
  int unsigned cyc = 0;
  bit          mon_en = 1'b0;

  typedef struct {
    int unsigned stamp;
    logic        sym;
    int unsigned fcnt;
  } sym_t;

  typedef struct {
    int unsigned stamp;
    int unsigned fcnt;
  } done_t;

  sym_t  sq[$];
  done_t dq[$];
  sym_t  se;
  done_t de;

  seq_bbccc_gen #(
    .B_SYM    (1'b0),
    .C_SYM    (1'b1),
    .IDLE_SYM (1'b1),
    .CNT_W    (CNT_W),
    .GAP_LEN  (G)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .reps      (reps),
    .stop      (stop),
    .dout      (dout),
    .dout_vld  (dout_vld),
    .busy      (busy),
    .done      (done),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s: unexpected event at cycle %0d", name, cyc);
  endtask

  // Monitor: compares DUT presentations against the predicted queues.
  always @(negedge clk) begin
    if (mon_en) begin
      if (dout_vld === 1'b1) begin
        if (sq.size() == 0) begin
          fail_now("unexpected_symbol");
        end else begin
          se = sq.pop_front();
          check("sym_cycle", cyc, se.stamp);
          check("dout", 32'(dout), 32'(se.sym));
          check("frame_cnt_mid", 32'(frame_cnt), se.fcnt);
          check("busy_mid", 32'(busy), 1);
        end
      end else begin
        check("idle_dout", 32'(dout), 1);
      end
      if (done === 1'b1) begin
        if (dq.size() == 0) begin
          fail_now("unexpected_done");
        end else begin
          de = dq.pop_front();
          check("done_cycle", cyc, de.stamp);
          check("done_frame_cnt", 32'(frame_cnt), de.fcnt);
          check("done_busy", 32'(busy), 0);
        end
      end
    end
  end

  // kind: 0 = run to completion, 1 = stop at cycle t0+a, 2 = reset at cycle t0+a.
  task automatic do_req(input int unsigned r_in, input int unsigned kind, input int unsigned a);
    int unsigned r, t0, len, stamp, fexp;
    r   = (r_in == 0) ? 1 : r_in;
    len = r * FL + (r - 1) * G;
    @(posedge clk); #1;
    t0    = cyc;
    start = 1'b1;
    reps  = CNT_W'(r_in);
    for (int unsigned f = 0; f < r; f++) begin
      for (int unsigned j = 0; j < FL; j++) begin
        stamp = t0 + 1 + f * P + j;
        if (kind == 0 || stamp <= t0 + a) begin
          sq.push_back('{stamp: stamp, sym: (j >= 2), fcnt: f});
        end
      end
    end
    if (kind == 0) dq.push_back('{stamp: t0 + 1 + len, fcnt: r});
    @(posedge clk); #1;
    start = 1'b0;
    reps  = CNT_W'($urandom);
    while (cyc < t0 + len + 1) begin
      if (kind != 0 && cyc == t0 + a) begin
        start = 1'b0;
        if (kind == 1) stop = 1'b1;
        else           rst  = 1'b1;
        @(posedge clk); #1;
        stop = 1'b0;
        rst  = 1'b0;
        fexp = 0;
        if (kind == 1) begin
          for (int unsigned f = 0; f < r; f++) if (f * P + FL < a) fexp++;
        end
        check("abort_vld", 32'(dout_vld), 0);
        check("abort_busy", 32'(busy), 0);
        check("abort_done", 32'(done), 0);
        check("abort_dout", 32'(dout), 1);
        check("abort_frame_cnt", 32'(frame_cnt), fexp);
        break;
      end
      // Requests and reps changes while busy must be ignored.
      start = ($urandom_range(0, 3) == 0);
      reps  = CNT_W'($urandom);
      @(posedge clk); #1;
    end
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int unsigned r, k, a, len;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_dout", 32'(dout), 1);
    check("rst_vld", 32'(dout_vld), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_frame_cnt", 32'(frame_cnt), 0);
    mon_en = 1'b1;
    repeat (5) @(posedge clk);

    do_req(1, 0, 0);
    do_req(3, 0, 0);
    do_req(0, 0, 0);
    do_req(2, 1, 4);
    do_req(3, 1, P + 4);

    @(posedge clk); #1;
    start = 1'b1;
    stop  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    stop  = 1'b0;
    check("stop_start_busy", 32'(busy), 0);
    check("stop_start_vld", 32'(dout_vld), 0);
    repeat (2) @(posedge clk);

    do_req(2, 2, 2);
    do_req(1, 0, 0);
    do_req(15, 0, 0);

    for (int i = 0; i < 20; i++) begin
      r   = $urandom_range(0, 15);
      len = ((r == 0) ? 1 : r) * P - G;
      k   = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
      a   = $urandom_range(1, len);
      do_req(r, k, a);
    end

    repeat (3) @(posedge clk);
    #1;
    check("symbols_left", sq.size(), 0);
    check("dones_left", dq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
